dspi_nor_ctrl: RTL and testbench
================================

DSPI_NOR_CTRL -- requirements
Module: dspi_nor_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2: sck half-period in clk cycles, legal range 1..255.
REQ-002 SHALL have parameter RD_CMD, default 8'hBB: read opcode sent on 2 lines.
REQ-003 SHALL have parameter CSH_CYC, default 4: minimum csb-high clk cycles between transactions, minimum 1.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: clk input 1 system clock; rstn input 1 async active-low reset.
REQ-005 req_vld input 1: read request valid.
REQ-006 req_rdy output 1: controller accepts request.
REQ-007 req_addr input 24: flash byte address.
REQ-008 req_size input 2: 0 = byte, 1 = halfword, 2 = word, 3 = reserved (treated as word).
REQ-009 resp_vld output 1: one-cycle read-data strobe.
REQ-010 resp_data output 32: read data, little-endian.
REQ-011 sck output 1: flash clock, mode 0, idle low.
REQ-012 csb output 1: flash chip select, active low.
REQ-013 dio_o output 2, dio_oe output 2, dio_i input 2: dual I/O; the pad tristate sits outside this block.

Function
REQ-014 req_rdy SHALL be 1 only in IDLE; a request is accepted on a clk edge where req_vld & req_rdy.
REQ-015 The FSM SHALL have states IDLE -> CMD (4 sck) -> ADDR (12 sck) -> DUMMY (8 sck) -> DATA (4*nbytes sck) -> GAP (CSH_CYC clk) -> IDLE.
REQ-016 With acceptance at edge T0, csb SHALL fall at T0+1.
REQ-017 sck rising edge k (k = 0..N-1, N = 24 + 4*nbytes) SHALL occur at T0+1+CLK_DIV*(2k+1).
REQ-018 sck falling edges SHALL occur CLK_DIV cycles after each rising edge, except after the last rising edge.
REQ-019 The controller SHALL drive dio_o at csb fall and at each sck falling edge; the flash samples on sck rising.
REQ-020 Bits SHALL be sent MSB-first, 2 bits per sck: RD_CMD[7:6] first, then req_addr[23:22] first.
REQ-021 dio_oe SHALL be 2'b11 during CMD and ADDR.
REQ-022 dio_oe SHALL go 2'b00 at the sck falling edge following the last address rising edge, and stay 0 through DUMMY, DATA, GAP and IDLE.
REQ-023 In DATA, dio_i SHALL be sampled on the clk edge producing each sck rising edge.
REQ-024 In DATA, each byte is received MSB-first (bits 7:6 first).
REQ-025 Byte i from address A+i SHALL land in resp_data[8i+7:8i].
REQ-026 resp_data bits above the requested size SHALL be 0.
REQ-027 csb SHALL rise, with sck low, at T0+1+2*CLK_DIV*N.
REQ-028 resp_vld SHALL pulse for exactly that one cycle.
REQ-029 resp_data SHALL be valid during the resp_vld cycle and held until the next acceptance.
REQ-030 Address wrap at 24'hFFFFFF is handled by the flash; the controller SHALL NOT check or split the access.
REQ-031 req_addr and req_size SHALL be latched at acceptance; later changes have no effect.
REQ-032 req_vld asserted outside IDLE SHALL be ignored, with no queueing.
REQ-033 The GAP state SHALL hold csb high for CSH_CYC cycles before req_rdy returns to 1.

Reset
REQ-034 On rstn low, all outputs SHALL take their reset values immediately, asynchronously, including mid-transaction.
REQ-035 Reset values: csb = 1, sck = 0, dio_oe = 0, dio_o = 0, resp_vld = 0, resp_data = 0, req_rdy = 0.
REQ-036 The FSM SHALL reset to IDLE.
REQ-037 req_rdy SHALL become 1 on the first clk edge after rstn deasserts.
REQ-038 An aborted transaction SHALL produce no resp_vld.

Structure
REQ-039 Package dspi_nor_pkg SHALL hold the FSM state enum, the size codes, and the phase lengths: CMD_SCK = 4, ADDR_SCK = 12, DUMMY_SCK = 8.
REQ-040 One sub-module, dspi_sck_gen, SHALL be used: a CLK_DIV counter that generates sck plus one-cycle rise/fall strokes.
REQ-041 The FSM and shift registers SHALL live in dspi_nor_ctrl.

Verification
REQ-042 The bench SHALL use a dual-I/O flash behavioural model preloaded with mem[i] = i[7:0].
REQ-043 Word read, addr 24'h000010, CLK_DIV = 2 -> resp_data = 32'h13121110.
REQ-044 Word read, same -> resp_vld exactly 1+2*2*40 = 161 cycles after acceptance.
REQ-045 Word read, same -> exactly 40 sck rising edges.
REQ-046 Byte read, addr 24'h0001FF -> resp_data = 32'h000000FF.
REQ-047 Halfword read, addr 24'h000005 -> resp_data = 32'h00000605.
REQ-048 Halfword read -> 32 sck rising edges.
REQ-049 Halfword read -> dio_oe = 0 from the 16th falling edge.
REQ-050 Back-to-back req_vld held high -> csb high >= CSH_CYC cycles between transactions.
REQ-051 Back-to-back req_vld held high -> req_rdy low throughout each transaction.
REQ-052 rstn pulsed low during DUMMY -> csb = 1, sck = 0, dio_oe = 0 within the same cycle.
REQ-053 After that reset, no resp_vld; the next request completes with correct data.
REQ-054 CLK_DIV = 1, req_size = 3 -> treated as a word.
REQ-055 With CLK_DIV = 1, sck period = 2 clk.
REQ-056 req_addr changed after acceptance -> returned data matches the latched address.

Source files
------------

// File: rtl/dspi_nor_pkg.sv
// Shared types and constants for the dual-I/O NOR read controller:
// FSM states, request size codes and the fixed sck counts of each phase.
package dspi_nor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_GAP
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_RSVD = 2'd3;

    localparam int CMD_SCK   = 4;
    localparam int ADDR_SCK  = 12;
    localparam int DUMMY_SCK = 8;
    localparam int PRE_SCK   = CMD_SCK + ADDR_SCK + DUMMY_SCK;

    // Total sck rising edges for one transaction; the reserved code reads a word.
    function automatic logic [5:0] total_sck(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 6'(PRE_SCK + 4);
            SZ_HALF: return 6'(PRE_SCK + 8);
            default: return 6'(PRE_SCK + 16);
        endcase
    endfunction

    // rx holds bytes in arrival order (first byte most significant); resp is little-endian.
    function automatic logic [31:0] pack_le(input logic [31:0] rx, input logic [1:0] size);
        case (size)
            SZ_BYTE: return {24'h0, rx[7:0]};
            SZ_HALF: return {16'h0, rx[7:0], rx[15:8]};
            default: return {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
        endcase
    endfunction

endpackage

// File: rtl/dspi_sck_gen.sv
// sck generator: toggles sck every CLK_DIV clk cycles while run is high and
// flags the clk edge that will produce each rising or falling sck edge.
module dspi_sck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic run,
    output logic sck,
    output logic rise,
    output logic fall
);

    logic [7:0] cnt;
    logic       wrap;

    assign wrap = run && (cnt == 8'(CLK_DIV - 1));
    assign rise = wrap && !sck;
    assign fall = wrap && sck;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= 8'd0;
            sck <= 1'b0;
        end else if (!run) begin
            cnt <= 8'd0;
            sck <= 1'b0;
        end else if (wrap) begin
            cnt <= 8'd0;
            sck <= ~sck;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/dspi_nor_ctrl.sv
// Dual-I/O (opcode 0xBB style) NOR flash read controller: one request in,
// one little-endian response out, with csb/sck/dio sequencing to the flash.
module dspi_nor_ctrl
    import dspi_nor_pkg::*;
#(
    parameter int         CLK_DIV = 2,
    parameter logic [7:0] RD_CMD  = 8'hBB,
    parameter int         CSH_CYC = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_vld,
    output logic        req_rdy,
    input  logic [23:0] req_addr,
    input  logic [1:0]  req_size,
    output logic        resp_vld,
    output logic [31:0] resp_data,
    output logic        sck,
    output logic        csb,
    output logic [1:0]  dio_o,
    output logic [1:0]  dio_oe,
    input  logic [1:0]  dio_i,
    output logic [2:0]  dbg_state
);

    // Handshake: a request transfers on a clk edge with req_vld & req_rdy; req_rdy is
    // high only in IDLE, so req_vld seen elsewhere is dropped, never queued.
    state_t      state;
    logic        run, rise, fall;
    logic [31:0] tx_sr, rx_sr;
    logic [5:0]  rcnt, n_sck;
    logic [1:0]  size_q;
    logic [7:0]  gcnt;

    assign dbg_state = state;

    dspi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck (
        .clk  (clk),
        .rstn (rstn),
        .run  (run),
        .sck  (sck),
        .rise (rise),
        .fall (fall)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            req_rdy   <= 1'b0;
            csb       <= 1'b1;
            run       <= 1'b0;
            dio_o     <= 2'b00;
            dio_oe    <= 2'b00;
            resp_vld  <= 1'b0;
            resp_data <= 32'h0;
            tx_sr     <= 32'h0;
            rx_sr     <= 32'h0;
            rcnt      <= 6'd0;
            n_sck     <= 6'd0;
            size_q    <= SZ_BYTE;
            gcnt      <= 8'd0;
        end else begin
            resp_vld <= 1'b0;
            if (rise)
                rcnt <= rcnt + 6'd1;
            case (state)
                ST_IDLE: begin
                    if (req_vld && req_rdy) begin
                        req_rdy <= 1'b0;
                        size_q  <= req_size;
                        n_sck   <= total_sck(req_size);
                        tx_sr   <= {RD_CMD, req_addr};
                        rx_sr   <= 32'h0;
                        rcnt    <= 6'd0;
                        state   <= ST_CMD;
                    end else begin
                        req_rdy <= 1'b1;
                    end
                end
                ST_CMD, ST_ADDR: begin
                    // First cycle of CMD drops csb and presents the opcode MSBs.
                    if (csb || fall) begin
                        csb    <= 1'b0;
                        run    <= 1'b1;
                        dio_oe <= 2'b11;
                        dio_o  <= tx_sr[31:30];
                        tx_sr  <= {tx_sr[29:0], 2'b00};
                    end
                    if (rise && rcnt == 6'(CMD_SCK - 1))
                        state <= ST_ADDR;
                    if (rise && rcnt == 6'(CMD_SCK + ADDR_SCK - 1))
                        state <= ST_DUMMY;
                end
                ST_DUMMY: begin
                    if (fall) begin
                        dio_oe <= 2'b00;
                        dio_o  <= 2'b00;
                    end
                    if (rise && rcnt == 6'(PRE_SCK - 1))
                        state <= ST_DATA;
                end
                ST_DATA: begin
                    if (rise)
                        rx_sr <= {rx_sr[29:0], dio_i};
                    // The would-be fall after the last rise ends the burst instead.
                    if (fall && rcnt == n_sck) begin
                        csb       <= 1'b1;
                        run       <= 1'b0;
                        resp_vld  <= 1'b1;
                        resp_data <= pack_le(rx_sr, size_q);
                        gcnt      <= 8'(CSH_CYC - 1);
                        state     <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gcnt == 8'd0) begin
                        state   <= ST_IDLE;
                        req_rdy <= 1'b1;
                    end else begin
                        gcnt <= gcnt - 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dspi_nor_ctrl.sv
// Bench for dspi_nor_ctrl: two instances (CLK_DIV 2 and 1) each talking to a
// dual-I/O flash model whose memory holds mem[i] = i[7:0].
module tb_dspi_nor_ctrl;
    import dspi_nor_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic [1:0]  req_vld, req_rdy, resp_vld, sck, csb;
    logic [23:0] req_addr [2];
    logic [1:0]  req_size [2];
    logic [31:0] resp_data [2];
    logic [1:0]  dio_o [2], dio_oe [2], dio_i [2];
    logic [2:0]  dbg_state [2];
    logic [7:0]  mem [1024];
    logic [31:0] exp_q [$];
    int          n_cmp = 0, n_err = 0;
    logic        t_csb0, t_csb1;

    always #5 clk = ~clk;

    initial for (int i = 0; i < 1024; i++) mem[i] = i[7:0];

    dspi_nor_ctrl #(.CLK_DIV(2), .RD_CMD(8'hBB), .CSH_CYC(4)) dut0 (
        .clk(clk), .rstn(rstn), .req_vld(req_vld[0]), .req_rdy(req_rdy[0]),
        .req_addr(req_addr[0]), .req_size(req_size[0]), .resp_vld(resp_vld[0]),
        .resp_data(resp_data[0]), .sck(sck[0]), .csb(csb[0]), .dio_o(dio_o[0]),
        .dio_oe(dio_oe[0]), .dio_i(dio_i[0]), .dbg_state(dbg_state[0])
    );

    dspi_nor_ctrl #(.CLK_DIV(1), .RD_CMD(8'h3B), .CSH_CYC(1)) dut1 (
        .clk(clk), .rstn(rstn), .req_vld(req_vld[1]), .req_rdy(req_rdy[1]),
        .req_addr(req_addr[1]), .req_size(req_size[1]), .resp_vld(resp_vld[1]),
        .resp_data(resp_data[1]), .sck(sck[1]), .csb(csb[1]), .dio_o(dio_o[1]),
        .dio_oe(dio_oe[1]), .dio_i(dio_i[1]), .dbg_state(dbg_state[1])
    );

    // Flash model plus a per-transaction monitor sampled on the falling clk edge.
    for (genvar g = 0; g < 2; g++) begin : flash
        int          fcnt = 0, p;
        logic [7:0]  fcmd = 8'h0, b;
        logic [23:0] faddr = 24'h0, baddr;
        logic [1:0]  drv = 2'b00;
        int          rises = 0, falls = 0, sck_hi = 0, hi_run = 0, min_gap = 100000, resp_cnt = 0;
        logic        oe_bad = 1'b0, rdy_bad = 1'b0, prev_sck = 1'b0, prev_csb = 1'b1;

        assign dio_i[g] = drv;

        always @(negedge csb[g]) fcnt = 0;

        always @(posedge sck[g]) begin
            if (!csb[g]) begin
                if (fcnt < 4)
                    fcmd = {fcmd[5:0], dio_o[g]};
                else if (fcnt < 16)
                    faddr = {faddr[21:0], dio_o[g]};
                fcnt = fcnt + 1;
            end
        end

        always @(negedge sck[g]) begin
            if (!csb[g] && fcnt >= 24) begin
                p     = fcnt - 24;
                baddr = faddr + 24'(p / 4);
                b     = mem[baddr[9:0]];
                drv   = b[6 - 2 * (p % 4) +: 2];
            end
        end

        always @(negedge clk) begin
            if (!csb[g]) begin
                if (prev_csb) begin
                    if (hi_run < min_gap) min_gap = hi_run;
                    rises = 0; falls = 0; sck_hi = 0; oe_bad = 1'b0;
                end
                if (!prev_sck && sck[g]) rises++;
                if (prev_sck && !sck[g]) falls++;
                if (sck[g]) sck_hi++;
                if ((falls >= 16) ? (dio_oe[g] !== 2'b00) : (dio_oe[g] !== 2'b11)) oe_bad = 1'b1;
                if (req_rdy[g]) rdy_bad = 1'b1;
                hi_run = 0;
            end else begin
                hi_run++;
            end
            if (resp_vld[g]) resp_cnt++;
            prev_sck = sck[g];
            prev_csb = csb[g];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic start_req(input int g, input logic [23:0] a, input logic [1:0] sz);
        int w;
        @(negedge clk);
        req_vld[g] = 1'b1; req_addr[g] = a; req_size[g] = sz;
        w = 0;
        while (req_rdy[g] !== 1'b1 && w < 50) begin @(negedge clk); w++; end
        check("rdy_wait", {31'h0, req_rdy[g]}, 32'h1);
        @(negedge clk);
        req_vld[g] = 1'b0;
    endtask

    task automatic do_read(input int g, input logic [23:0] a, input logic [1:0] sz,
                           input bit scramble, output logic [31:0] data, output int lat);
        start_req(g, a, sz);
        if (scramble) begin req_addr[g] = ~a; req_size[g] = ~sz; end
        lat = 0;
        t_csb0 = csb[g];
        while (resp_vld[g] !== 1'b1 && lat < 400) begin
            @(negedge clk);
            lat++;
            if (lat == 1) t_csb1 = csb[g];
        end
        data = resp_data[g];
    endtask

    initial begin
        logic [31:0] d;
        int          lat, rc, w;
        rstn = 1'b0; req_vld = 2'b00;
        req_addr[0] = '0; req_addr[1] = '0; req_size[0] = '0; req_size[1] = '0;
        #12;
        check("rst_csb",    {31'h0, csb[0]}, 32'h1);
        check("rst_sck",    {31'h0, sck[0]}, 32'h0);
        check("rst_oe",     {30'h0, dio_oe[0]}, 32'h0);
        check("rst_dio",    {30'h0, dio_o[0]}, 32'h0);
        check("rst_vld",    {31'h0, resp_vld[0]}, 32'h0);
        check("rst_data",   resp_data[0], 32'h0);
        check("rst_rdy",    {31'h0, req_rdy[0]}, 32'h0);
        @(negedge clk); rstn = 1'b1;
        @(negedge clk);
        check("rdy_after_rst", {31'h0, req_rdy[0]}, 32'h1);

        do_read(0, 24'h000010, 2'd2, 1'b0, d, lat);
        check("word_data",   d, 32'h13121110);
        check("word_lat",    lat, 161);
        check("word_rises",  flash[0].rises, 40);
        check("word_sck_hi", flash[0].sck_hi, 80);
        check("word_cmd",    {24'h0, flash[0].fcmd}, 32'h000000BB);
        check("word_addr",   {8'h0, flash[0].faddr}, 32'h00000010);
        check("word_oe",     {31'h0, flash[0].oe_bad}, 32'h0);
        check("csb_at_t0",   {31'h0, t_csb0}, 32'h1);
        check("csb_at_t1",   {31'h0, t_csb1}, 32'h0);
        check("end_csb",     {31'h0, csb[0]}, 32'h1);
        check("end_sck",     {31'h0, sck[0]}, 32'h0);
        @(negedge clk);
        check("vld_one_cyc", {31'h0, resp_vld[0]}, 32'h0);
        check("data_held",   resp_data[0], 32'h13121110);

        do_read(0, 24'h0001FF, 2'd0, 1'b0, d, lat);
        check("byte_data", d, 32'h000000FF);
        check("byte_lat",  lat, 113);

        do_read(0, 24'h000005, 2'd1, 1'b0, d, lat);
        check("half_data",  d, 32'h00000605);
        check("half_lat",   lat, 129);
        check("half_rises", flash[0].rises, 32);
        check("half_oe",    {31'h0, flash[0].oe_bad}, 32'h0);

        do_read(0, 24'h000100, 2'd2, 1'b1, d, lat);
        check("latch_data", d, 32'h03020100);
        check("latch_addr", {8'h0, flash[0].faddr}, 32'h00000100);

        repeat (3) exp_q.push_back(32'h23222120);
        @(negedge clk);
        req_vld[0] = 1'b1; req_addr[0] = 24'h000020; req_size[0] = 2'd2;
        rc = 0;
        for (int c = 0; c < 1500 && rc < 3; c++) begin
            @(negedge clk);
            if (resp_vld[0]) begin
                rc++;
                check("b2b_data", resp_data[0], exp_q.pop_front());
            end
        end
        req_vld[0] = 1'b0;
        check("b2b_count",  rc, 3);
        check("b2b_gap_ok", {31'h0, flash[0].min_gap >= 4}, 32'h1);
        check("b2b_rdy",    {31'h0, flash[0].rdy_bad}, 32'h0);

        start_req(0, 24'h000050, 2'd2);
        w = 0;
        while (dbg_state[0] !== 3'(ST_DUMMY) && w < 300) begin @(negedge clk); w++; end
        check("reach_dummy", {29'h0, dbg_state[0]}, {29'h0, 3'(ST_DUMMY)});
        repeat (3) @(negedge clk);
        rc = flash[0].resp_cnt;
        #2 rstn = 1'b0;
        #1;
        check("abort_csb", {31'h0, csb[0]}, 32'h1);
        check("abort_sck", {31'h0, sck[0]}, 32'h0);
        check("abort_oe",  {30'h0, dio_oe[0]}, 32'h0);
        check("abort_rdy", {31'h0, req_rdy[0]}, 32'h0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (200) @(negedge clk);
        check("abort_no_resp", flash[0].resp_cnt, rc);
        do_read(0, 24'h0003FE, 2'd2, 1'b0, d, lat);
        check("post_abort_data", d, 32'h0100FFFE);
        check("post_abort_lat",  lat, 161);

        do_read(1, 24'h000080, 2'd3, 1'b0, d, lat);
        check("div1_data",   d, 32'h83828180);
        check("div1_lat",    lat, 81);
        check("div1_rises",  flash[1].rises, 40);
        check("div1_sck_hi", flash[1].sck_hi, 40);
        check("div1_cmd",    {24'h0, flash[1].fcmd}, 32'h0000003B);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
